// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for a short in-order pipeline.
// A small shift-register tracker mirrors the destination information of the
// instructions that are in flight ahead of decode. Entry 0 is the instruction
// currently in EX and entry k is k+1 instructions older than the decode
// instruction. A decode operand that needs a load result which is not yet
// usable causes a one-cycle stall. Otherwise a registered select steers the
// EX operand mux to the youngest matching producer.

module fwd_hazard_unit #(
  parameter int DWIDTH   = 16,
  parameter int RADDR    = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [RADDR-1:0]             id_rs,
  input  logic [RADDR-1:0]             id_rt,
  input  logic                         id_rs_rd,
  input  logic                         id_rt_rd,
  input  logic [RADDR-1:0]             id_rd,
  input  logic                         id_regwrite,
  input  logic                         id_load,
  input  logic                         flush,
  input  logic [DWIDTH-1:0]            ex_naked_a,
  input  logic [DWIDTH-1:0]            ex_naked_b,
  input  logic [NSRC*DWIDTH-1:0]       src_data,
  output logic                         stall,
  output logic [DWIDTH-1:0]            ex_op_a,
  output logic [DWIDTH-1:0]            ex_op_b,
  output logic [$clog2(NSRC+1)-1:0]    ex_sel_a,
  output logic [$clog2(NSRC+1)-1:0]    ex_sel_b,
  output logic [15:0]                  stall_cnt
);

  localparam int SELW = $clog2(NSRC+1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Tracker storage, one slot per forwarding source.
  logic [NSRC-1:0]  ent_valid_q, ent_valid_d;
  logic [NSRC-1:0]  ent_regwrite_q, ent_regwrite_d;
  logic [NSRC-1:0]  ent_load_q, ent_load_d;
  logic [RADDR-1:0] ent_rd_q [NSRC];
  logic [RADDR-1:0] ent_rd_d [NSRC];

  logic [SELW-1:0]  sel_a_q, sel_a_d;
  logic [SELW-1:0]  sel_b_q, sel_b_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic [NSRC-1:0]  match_a;
  logic [NSRC-1:0]  match_b;
  logic             load_hit;
  logic             hazard;
  logic             issue;
  logic [SELW-1:0]  fwd_a;
  logic [SELW-1:0]  fwd_b;

  // Compare each in-flight destination against the decode source specifiers.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int j = 0; j < NSRC; j++) begin
      match_a[j] = ent_valid_q[j] & ent_regwrite_q[j] &
                   (ent_rd_q[j] == id_rs) & id_rs_rd;
      match_b[j] = ent_valid_q[j] & ent_regwrite_q[j] &
                   (ent_rd_q[j] == id_rt) & id_rt_rd;
    end
  end

  // Load-use hazard: a matching load whose data is still too young to forward.
  always_comb begin
    load_hit = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      if (j < LOAD_LAT) begin
        if (ent_load_q[j] & (match_a[j] | match_b[j])) begin
          load_hit = 1'b1;
        end
      end
    end
    hazard = id_valid & load_hit;
    // Flush kills the decode instruction, so it can never be stalled.
    stall  = hazard & ~flush;
    issue  = id_valid & ~stall & ~flush;
  end

  // Priority encode matches: scan oldest to youngest so the youngest wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int j = NSRC-1; j >= 0; j--) begin
      if (match_a[j]) fwd_a = SELW'(j+1);
      if (match_b[j]) fwd_b = SELW'(j+1);
    end
  end

  // Next-state for the tracker, selects and stall counter.
  always_comb begin
    // Entry 0 takes the decode instruction only when it actually issues.
    ent_valid_d[0]    = issue;
    ent_regwrite_d[0] = id_regwrite;
    ent_load_d[0]     = id_load;
    ent_rd_d[0]       = id_rd;
    // Flush kills the EX instruction before it shifts, so it ages as a bubble.
    for (int j = 1; j < NSRC; j++) begin
      if (j == 1) begin
        ent_valid_d[j] = ent_valid_q[0] & ~flush;
      end else begin
        ent_valid_d[j] = ent_valid_q[j-1];
      end
      ent_regwrite_d[j] = ent_regwrite_q[j-1];
      ent_load_d[j]     = ent_load_q[j-1];
      ent_rd_d[j]       = ent_rd_q[j-1];
    end

    sel_a_d = issue ? fwd_a : '0;
    sel_b_d = issue ? fwd_b : '0;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers; reset empties the tracker, which also drops any stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid_q    <= '0;
      ent_regwrite_q <= '0;
      ent_load_q     <= '0;
      for (int j = 0; j < NSRC; j++) begin
        ent_rd_q[j] <= '0;
      end
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_valid_q    <= ent_valid_d;
      ent_regwrite_q <= ent_regwrite_d;
      ent_load_q     <= ent_load_d;
      for (int j = 0; j < NSRC; j++) begin
        ent_rd_q[j] <= ent_rd_d[j];
      end
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // EX operand mux: select 0 is the register-file value, k+1 is source k.
  always_comb begin
    ex_op_a = ex_naked_a;
    ex_op_b = ex_naked_b;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_a_q == SELW'(k+1)) ex_op_a = src_data[k*DWIDTH +: DWIDTH];
      if (sel_b_q == SELW'(k+1)) ex_op_b = src_data[k*DWIDTH +: DWIDTH];
    end
  end

  assign ex_sel_a  = sel_a_q;
  assign ex_sel_b  = sel_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with the default configuration
// (DWIDTH=16, NSRC=2, LOAD_LAT=1).

module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        id_rs_rd, id_rt_rd, id_regwrite, id_load;
  logic        flush;
  logic [15:0] ex_naked_a, ex_naked_b;
  logic [31:0] src_data;
  logic        stall;
  logic [15:0] ex_op_a, ex_op_b;
  logic [1:0]  ex_sel_a, ex_sel_b;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] NAK_A = 16'hAAAA;
  localparam logic [15:0] NAK_B = 16'hBBBB;
  localparam logic [15:0] SRC0  = 16'h1234;
  localparam logic [15:0] SRC1  = 16'h5678;

  fwd_hazard_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_rd   (id_rs_rd),
    .id_rt_rd   (id_rt_rd),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_load    (id_load),
    .flush      (flush),
    .ex_naked_a (ex_naked_a),
    .ex_naked_b (ex_naked_b),
    .src_data   (src_data),
    .stall      (stall),
    .ex_op_a    (ex_op_a),
    .ex_op_b    (ex_op_b),
    .ex_sel_a   (ex_sel_a),
    .ex_sel_b   (ex_sel_b),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                       input logic rsr, input logic rtr, input logic [2:0] rd,
                       input logic rw, input logic ld);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rs_rd    = rsr;
    id_rt_rd    = rtr;
    id_rd       = rd;
    id_regwrite = rw;
    id_load     = ld;
  endtask

  logic [15:0] sat_exp [3];

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    ex_naked_a = NAK_A;
    ex_naked_b = NAK_B;
    src_data   = {SRC1, SRC0};
    instr(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Reset state
    #12;
    check("rst_stall", stall, 1'b0);
    check("rst_sel_a", ex_sel_a, 2'd0);
    check("rst_sel_b", ex_sel_b, 2'd0);
    check("rst_cnt", stall_cnt, 16'd0);
    check("rst_op_a", ex_op_a, NAK_A);
    check("rst_op_b", ex_op_b, NAK_B);
    rst_n = 1'b1;

    // ADD r3 then SUB r4,r3,r3: both operands forward from source 0
    tick();
    instr(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    check("add_first_sel_a", ex_sel_a, 2'd0);
    instr(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    #1;
    check("alu_dep_no_stall", stall, 1'b0);
    tick();
    check("fwd0_sel_a", ex_sel_a, 2'd1);
    check("fwd0_sel_b", ex_sel_b, 2'd1);
    check("fwd0_op_a", ex_op_a, SRC0);
    check("fwd0_op_b", ex_op_b, SRC0);

    // LD r2 then ADD r5,r2,r1: one stall, then forward from source 1
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    check("ld_sel_a", ex_sel_a, 2'd0);
    instr(1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
    #1;
    check("lu_stall", stall, 1'b1);
    tick();
    check("lu_cnt1", stall_cnt, 16'd1);
    check("lu_sel_bubble", ex_sel_a, 2'd0);
    check("lu_op_bubble", ex_op_a, NAK_A);
    check("lu_stall_once", stall, 1'b0);
    tick();
    check("lu_sel_a", ex_sel_a, 2'd2);
    check("lu_sel_b", ex_sel_b, 2'd0);
    check("lu_op_a", ex_op_a, SRC1);
    check("lu_op_b", ex_op_b, NAK_B);
    check("lu_cnt_hold", stall_cnt, 16'd1);

    // ADD r1, ADD r1, reader of r1: the youngest producer wins
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    tick();
    instr(1'b1, 3'd1, 3'd7, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    tick();
    check("young_sel_a", ex_sel_a, 2'd1);
    check("young_sel_b", ex_sel_b, 2'd0);

    // Invalid decode gets select 0; then an ALU producer one slot back uses source 1
    instr(1'b0, 3'd6, 3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    tick();
    check("invalid_sel_a", ex_sel_a, 2'd0);
    instr(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check("fwd1_sel_a", ex_sel_a, 2'd2);
    check("fwd1_op_a", ex_op_a, SRC1);

    // Hazard with flush: flush wins, killed load never becomes visible
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    instr(1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_no_stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    check("flush_cnt", stall_cnt, 16'd1);
    check("flush_sel_a", ex_sel_a, 2'd0);
    #1;
    check("flush_e0_invalid", stall, 1'b0);
    tick();
    check("flush_e1_invalid", ex_sel_a, 2'd0);

    // Rt not read: no stall even though rt names the pending load
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    instr(1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
    #1;
    check("rt_unread_stall", stall, 1'b0);
    tick();
    check("rt_unread_sel_b", ex_sel_b, 2'd0);
    check("rt_unread_cnt", stall_cnt, 16'd1);

    // Rt read: load-use hazard on operand B
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    instr(1'b1, 3'd0, 3'd2, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    #1;
    check("rt_stall", stall, 1'b1);
    tick();
    check("rt_cnt2", stall_cnt, 16'd2);
    tick();
    check("rt_sel_b", ex_sel_b, 2'd2);
    check("rt_op_b", ex_op_b, SRC1);

    // Saturation: preload the counter near the top, then add three stalls
    instr(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat_preload", stall_cnt, 16'hFFFD);
    sat_exp[0] = 16'hFFFE;
    sat_exp[1] = 16'hFFFF;
    sat_exp[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
      tick();
      instr(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
      #1;
      check("sat_stall", stall, 1'b1);
      tick();
      check("sat_cnt", stall_cnt, sat_exp[i]);
      instr(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    end

    // Reset asserted mid-stall clears everything without a clock edge
    tick();
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
    tick();
    instr(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    check("pre_rst_sel_a", ex_sel_a, 2'd1);
    check("pre_rst_op_a", ex_op_a, SRC0);
    instr(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    #1;
    check("pre_rst_stall", stall, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_cnt", stall_cnt, 16'd0);
    check("mid_rst_sel_a", ex_sel_a, 2'd0);
    check("mid_rst_op_a", ex_op_a, NAK_A);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_stall", stall, 1'b0);

    // First edges after reset behave normally
    instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
    tick();
    check("post_rst_sel0", ex_sel_a, 2'd0);
    instr(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    tick();
    check("post_rst_sel_a", ex_sel_a, 2'd1);
    check("post_rst_cnt", stall_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter DWIDTH, default 16: operand and forwarded data width.
REQ-002 Parameter RADDR, default 3: register specifier width.
REQ-003 Parameter NSRC, default 2, range 1..4: forwarding sources; source k is the result of the producer k+1 instructions older than the consumer.
REQ-004 Parameter LOAD_LAT, default 1, range 1..NSRC: load results are unusable from sources 0..LOAD_LAT-1.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs, id_rt  in  RADDR  decode source specifiers
- id_rs_rd, id_rt_rd  in  1  decode reads Rs / Rt
- id_rd  in  RADDR  decode destination
- id_regwrite  in  1  decode writes id_rd
- id_load  in  1  decode instruction is a load
- flush  in  1  kill the decode instruction and the instruction in EX
- ex_naked_a, ex_naked_b  in  DWIDTH  register-file operands latched into EX
- src_data  in  NSRC*DWIDTH  source k at bits [k*DWIDTH +: DWIDTH]
- stall  out  1  hold PC and IF/ID; insert a bubble into EX
- ex_op_a, ex_op_b  out  DWIDTH  forwarded EX operands
- ex_sel_a, ex_sel_b  out  clog2(NSRC+1)  0 = naked, k+1 = source k
- stall_cnt  out  16  saturating count of stall cycles

Function
REQ-007 The block SHALL keep an NSRC-entry tracker; each entry holds {valid, rd, regwrite, load}; entry 0 is the instruction in EX.
REQ-008 An entry SHALL match operand X when valid & regwrite & (rd == id_X) & id_X_rd.
REQ-009 The hazard SHALL be asserted when id_valid and either operand matches an entry j with load=1 and j < LOAD_LAT.
REQ-010 stall SHALL be combinational: id_valid & hazard & ~flush.
REQ-011 On each clock edge, entry j SHALL take entry j-1 for j >= 1.
REQ-012 On each clock edge, entry 0 SHALL take {1, id_rd, id_regwrite, id_load} when id_valid & ~stall & ~flush; otherwise it SHALL become invalid (bubble).
REQ-013 flush SHALL invalidate entry 0 in the same edge it is sampled, before the shift, so the killed EX instruction propagates as invalid.
REQ-014 On each clock edge, ex_sel_a/b SHALL register the select for the decode instruction: (lowest matching index j)+1, else 0.
REQ-015 The select SHALL be registered as 0 when stall, flush, or ~id_valid.
REQ-016 The youngest producer (lowest index) SHALL win when several entries match.
REQ-017 ex_op_a/b SHALL be a combinational mux: ex_naked when sel = 0, else src_data source sel-1.
REQ-018 Forwarding latency SHALL be: the producer at entry j when the consumer is in decode feeds the consumer in EX from source j.
REQ-019 stall_cnt SHALL increment on each edge where stall=1 and SHALL hold at 16'hFFFF.
REQ-020 Simultaneous flush and hazard: flush SHALL win; stall=0 and no count.

Reset
REQ-021 While rst_n=0: all entries invalid, ex_sel_a/b=0, stall_cnt=0.
REQ-022 While rst_n=0, stall=0 follows from empty entries; ex_op_a/b SHALL equal ex_naked_a/b.
REQ-023 Reset asserted mid-stall SHALL clear the stall immediately.
REQ-024 After rst_n deasserts, the first edge SHALL behave as normal operation.

Verification (DWIDTH=16, NSRC=2, LOAD_LAT=1)
REQ-025 Sequence ADD r3 then SUB r4,r3,r3 -> next cycle ex_sel_a=ex_sel_b=1, ex_op_a=src_data[15:0]=16'h1234.
REQ-026 Sequence LD r2 then ADD r5,r2,r1 -> stall=1 for exactly one cycle; then ex_sel_a=2, ex_op_a=src_data[31:16]; stall_cnt=1.
REQ-027 Sequence ADD r1, ADD r1, then reader of r1 -> ex_sel_a=1 (youngest wins).
REQ-028 Hazard cycle with flush=1 -> stall=0, entry 0 invalid next edge, stall_cnt unchanged.
REQ-029 Reader with id_rt_rd=0 whose rt equals a pending load rd -> stall=0, ex_sel_b=0.
REQ-030 Force 65536 stall cycles -> stall_cnt holds 16'hFFFF.
REQ-031 rst_n low mid-stall -> stall=0 and counters zero asynchronously.
